demux_router: RTL
=================

Name: demux_router

Overview:
- Registered 1-to-31 demultiplexer, the distribution counterpart of the 31:1 select mux.
- Accepts one DATA_W word plus a 5-bit destination per handshake and delivers it into one of NUM_CH one-entry output slots.
- Each slot has its own valid/ready handshake.
- Selects beyond the last channel are dropped and flagged.
- Sits between a single producer and 31 independent consumers.

Parameters:
- DATA_W, 2, width of each data word.
- SEL_W, 5, width of destination select.
- NUM_CH, 31, number of output channels; legal sel range is 0..NUM_CH-1.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  router accepts the word this cycle.
- in_sel  input  SEL_W  destination channel.
- in_data  input  DATA_W  payload.
- out_valid  output  NUM_CH  per-channel slot full.
- out_ready  input  NUM_CH  per-channel consumer accepts.
- out_data  output  NUM_CH*DATA_W  flattened slot data; channel k occupies bits [k*DATA_W +: DATA_W].
- drop_err  output  1  sticky; set when an illegal sel is accepted.
- drop_count  output  CNT_W  count of dropped words (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, independent of clk):
  - all out_valid = 0, out_data = 0, drop_err = 0, drop_count = 0.
  - in_ready evaluates to 0 while reset is high.
- Legal sel (in_sel < NUM_CH):
  - in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational; a full slot that is draining this cycle can accept (pass-through refill).
- Illegal sel (in_sel >= NUM_CH, i.e. 31 at defaults): in_ready = 1. The word is always accepted and discarded.
- Accept condition: in_valid & in_ready. Data and sel are sampled on that edge.
- Latency: the accepted word appears in slot in_sel with out_valid high on the cycle after acceptance.
- Per-slot next state, evaluated at each rising edge:
  - load (accept targeting this slot): out_valid <= 1, out_data <= in_data. Load wins over drain when both happen in the same cycle.
  - drain only (out_valid & out_ready, no load): out_valid <= 0, out_data holds its last value.
  - neither: hold.
- Slots are independent. Simultaneous drains on any subset of channels are all honoured in one cycle. At most one load occurs per cycle.
- out_data of a slot is stable while out_valid=1 and out_ready=0. The consumer may rely on this.
- out_ready on a slot with out_valid=0 has no effect.
- Illegal-sel accept:
  - drop_err <= 1; it clears only on reset.
  - drop_count increments by 1 and saturates at 2^CNT_W-1; it does not wrap.
- in_valid=0: no state change other than drains. in_sel and in_data are don't-care.
- Reset asserted mid-transfer: pending slot contents are lost and no partial transfer completes.

Optional Feature:
- Macro: DEMUX_ROUTER_DROP_CNT_EN.
- Defined: drop_count is a CNT_W saturating counter as described above.
- Undefined: no counter register is built and drop_count is tied to 0. drop_err behaves identically in both builds.

Decomposition:
- Package demux_router_pkg holds:
  - constants DATA_W_DEF=2, SEL_W_DEF=5, NUM_CH_DEF=31;
  - a function is_legal_sel(sel) returning sel < NUM_CH.
- Sub-module demux_slot: a one-entry holding register with load/drain logic, ports clk, reset, load, load_data, ready, valid, data. It is instantiated NUM_CH times via generate.
- The top level holds the sel decode, in_ready mux, drop_err and the optional counter.

Test Plan:
- Reset release, then in_sel=3, in_data=2'b10, in_valid=1 for 1 cycle, out_ready=0 -> next cycle out_valid[3]=1, out_data ch3=2'b10; all other out_valid=0.
- Slot 3 full with out_ready[3]=0, new word to sel=3 -> in_ready=0 and slot keeps 2'b10. Raise out_ready[3] in the same cycle -> in_ready=1 and slot reloads with the new data; out_valid[3] stays 1.
- Stream sel=0..30 back-to-back with data=sel[1:0], all out_ready=1 -> each channel k shows valid for exactly one cycle, one cycle after its accept, with data k[1:0]; in_ready stays 1 throughout.
- sel=31, in_valid=1 for 300 cycles -> in_ready=1 every cycle, no out_valid rises, drop_err=1 after the first accept. drop_count=255 (saturated) with DEMUX_ROUTER_DROP_CNT_EN; drop_count=0 without it.
- Fill channels 5 and 20, then assert out_ready[5] and out_ready[20] together -> both out_valid clear on the same edge.
- Assert reset asynchronously mid-cycle with 4 slots full -> out_valid=0 and drop_err=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/demux_router_pkg.sv
// Shared constants and helpers for the demux_router 1-to-NUM_CH distributor.
package demux_router_pkg;

   localparam int DATA_W_DEF = 2;
   localparam int SEL_W_DEF  = 5;
   localparam int NUM_CH_DEF = 31;
   localparam int CNT_W_DEF  = 8;

   // A destination is legal when it names an existing output channel.
   function automatic logic is_legal_sel(input int unsigned sel,
                                         input int unsigned num_ch = NUM_CH_DEF);
      return sel < num_ch;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake.
// A load in the same cycle as a drain wins, giving pass-through refill.
module demux_slot
   import demux_router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Next-state: load beats drain; a drain alone clears valid but keeps data.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot state register; contents are cleared on reset so out_data reads zero.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: state uses non-blocking assignments so all slots update from the same pre-edge values.
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-NUM_CH demultiplexer: one producer, NUM_CH one-entry slots.
// Selects beyond the last channel are accepted, discarded and flagged.
// Build option: define DEMUX_ROUTER_DROP_CNT_EN to get a saturating drop counter;
// otherwise drop_count is tied to zero.
module demux_router
   import demux_router_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = SEL_W_DEF,
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [DATA_W-1:0]        in_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     drop_err,
   output logic [CNT_W-1:0]         drop_count
);

   logic              sel_legal;
   logic              sel_blocked;
   logic              accept;
   logic              drop_acc;
   logic [NUM_CH-1:0] load_vec;
   logic              drop_err_q, drop_err_d;

   assign sel_legal = is_legal_sel(32'(in_sel), 32'(NUM_CH));

   // Decode the destination: is the chosen slot full and not draining, and which slot loads.
   always_comb begin
      sel_blocked = 1'b0;
      load_vec    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_blocked = out_valid[k] & ~out_ready[k];
            load_vec[k] = accept;
         end
      end
   end

   // Illegal selects are always taken; nothing is taken while reset is high.
   assign in_ready = ~reset & (~sel_legal | ~sel_blocked);
   assign accept   = in_valid & in_ready;
   assign drop_acc = accept & ~sel_legal;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(.DATA_W(DATA_W)) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (load_vec[k]),
         .load_data (in_data),
         .ready     (out_ready[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*DATA_W +: DATA_W])
      );
   end

   // Sticky drop flag: set by any discarded word, cleared only by reset.
   always_comb begin
      drop_err_d = drop_err_q | drop_acc;
   end

   // Drop flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_err_q <= 1'b0;
      else       drop_err_q <= drop_err_d;
   end

   assign drop_err = drop_err_q;

`ifdef DEMUX_ROUTER_DROP_CNT_EN
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of discarded words; holds at all-ones instead of wrapping.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_acc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   // Drop counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`else
   assign drop_count = '0;
`endif

endmodule
